// File: rtl/pi_output_conditioner_if.sv
// DAC-side valid/ready bus of the PI output conditioner.
// master drives data/valid, slave returns ready.
interface pi_output_conditioner_if #(
    parameter int DATA_WIDTH = 16
);
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/pi_output_conditioner.sv
// PI output conditioner: window clamp, slew limit, DAC handshake, ramp-down.
// Optional overrun counter enabled by macro OUTCOND_OVERRUN_COUNT_EN.
module pi_output_conditioner #(
    parameter int DATA_WIDTH = 16,
    parameter int STEP_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] upper_limit,
    input  logic signed [DATA_WIDTH-1:0] lower_limit,
    input  logic        [STEP_WIDTH-1:0] max_step,
    pi_output_conditioner_if.master      dac,
    output logic                         limiting,
    output logic                         config_error,
    output logic                  [15:0] overrun_count
);

    localparam int XW =
        ((DATA_WIDTH + 1 > STEP_WIDTH) ? DATA_WIDTH + 1 : STEP_WIDTH) + 2;

    localparam logic signed [XW-1:0] DMAX =
        {{(XW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] DMIN =
        {{(XW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RAMP_DOWN
    } state_t;

    state_t state, state_nxt;

    logic                         load;
    logic signed [DATA_WIDTH-1:0] lo_c;
    logic signed [DATA_WIDTH-1:0] c1;
    logic                         hit1;

    logic                         s1_valid;
    logic signed [DATA_WIDTH-1:0] s1_c;
    logic                         s1_hit;
    logic signed [DATA_WIDTH-1:0] prev;

    logic                         slot_free;
    logic                         ramp_emit;
    logic                         s2_fire;
    logic signed [DATA_WIDTH-1:0] tgt;
    logic                         tgt_hit;
    logic signed [XW-1:0]         prev_x;
    logic signed [XW-1:0]         delta;
    logic signed [XW-1:0]         mag;
    logic signed [XW-1:0]         step_x;
    logic signed [XW-1:0]         stepped;
    logic signed [XW-1:0]         sat;
    logic                         slew_hit;
    logic signed [DATA_WIDTH-1:0] s2_new;
    logic                         unused_sat_hi;

    function automatic logic signed [XW-1:0] sx(
        input logic signed [DATA_WIDTH-1:0] v
    );
        return {{(XW-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    endfunction

    assign load = enable && in_valid;
    assign unused_sat_hi = ^sat[XW-1:DATA_WIDTH];

    // Stage 1: window clamp, forced to zero while limits are inconsistent
    always_comb begin
        lo_c = (in_data < lower_limit) ? lower_limit : in_data;
        c1   = (lo_c > upper_limit) ? upper_limit : lo_c;
        hit1 = (c1 != in_data);
        if (config_error) begin
            c1   = '0;
            hit1 = 1'b1;
        end
    end

    // Stage 2: slew limit toward the clamped sample or toward zero on ramp
    always_comb begin
        slot_free = !dac.out_valid || dac.out_ready;
        ramp_emit = (state == RAMP_DOWN) && !load && !s1_valid && slot_free;
        s2_fire   = s1_valid || ramp_emit;
        tgt       = s1_valid ? s1_c : '0;
        tgt_hit   = s1_valid && s1_hit;
        prev_x    = sx(prev);
        delta     = sx(tgt) - prev_x;
        mag       = (delta < 0) ? -delta : delta;
        step_x    = {{(XW-STEP_WIDTH){1'b0}}, max_step};
        slew_hit  = (max_step != '0) && (mag > step_x);
        stepped   = (delta < 0) ? prev_x - step_x : prev_x + step_x;
        sat       = stepped;
        if (stepped > DMAX) begin
            sat = DMAX;
        end else if (stepped < DMIN) begin
            sat = DMIN;
        end
        s2_new = slew_hit ? sat[DATA_WIDTH-1:0] : tgt;
    end

    // Next-state: RUN drains stage 1 before leaving, RAMP_DOWN ends at zero
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable && !s1_valid) begin
                    state_nxt = (prev != '0) ? RAMP_DOWN : IDLE;
                end
            end
            RAMP_DOWN: begin
                if (load) begin
                    state_nxt = RUN;
                end else if (ramp_emit && s2_new == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pipeline, output slot and state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            config_error  <= 1'b0;
            s1_valid      <= 1'b0;
            s1_c          <= '0;
            s1_hit        <= 1'b0;
            prev          <= '0;
            dac.out_data  <= '0;
            dac.out_valid <= 1'b0;
            limiting      <= 1'b0;
        end else begin
            state        <= state_nxt;
            config_error <= (lower_limit > upper_limit);
            s1_valid     <= load;
            if (load) begin
                s1_c   <= c1;
                s1_hit <= hit1;
            end
            if (s2_fire) begin
                prev          <= s2_new;
                dac.out_data  <= s2_new;
                dac.out_valid <= 1'b1;
                limiting      <= tgt_hit | slew_hit;
            end else if (dac.out_valid && dac.out_ready) begin
                dac.out_valid <= 1'b0;
            end
        end
    end

`ifdef OUTCOND_OVERRUN_COUNT_EN
    logic [15:0] ovr_cnt;

    // Count pending samples overwritten while the DAC stalls
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovr_cnt <= '0;
        end else if (s2_fire && dac.out_valid && !dac.out_ready
                     && ovr_cnt != 16'hFFFF) begin
            ovr_cnt <= ovr_cnt + 16'd1;
        end
    end

    assign overrun_count = ovr_cnt;
`else
    assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_pi_output_conditioner.sv
// Testbench for pi_output_conditioner: vector table, directed
// multi-cycle sequences and randomized traffic against a model.
module tb_pi_output_conditioner;

    logic               clk;
    logic               reset;
    logic               enable;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic signed [15:0] upper_limit;
    logic signed [15:0] lower_limit;
    logic        [15:0] max_step;
    logic               limiting;
    logic               config_error;
    logic        [15:0] overrun_count;

    pi_output_conditioner_if #(.DATA_WIDTH(16)) dac ();

    pi_output_conditioner #(
        .DATA_WIDTH(16),
        .STEP_WIDTH(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .upper_limit  (upper_limit),
        .lower_limit  (lower_limit),
        .max_step     (max_step),
        .dac          (dac.master),
        .limiting     (limiting),
        .config_error (config_error),
        .overrun_count(overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef OUTCOND_OVERRUN_COUNT_EN
    localparam logic [15:0] EXP_OVR = 16'd2;
`else
    localparam logic [15:0] EXP_OVR = 16'd0;
`endif

    typedef struct {
        logic [15:0] din;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [15:0] exp_out;
        logic        exp_lim;
        logic        exp_cfg;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } exp_t;

    vec_t        tbl[10];
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          vectors;
    int          errors;
    bit          mon_en;
    int          m_prev;
    logic [15:0] ramp_d[$];
    logic        ramp_l[$];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input logic [15:0] v);
        in_data  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    // Reference: clamp to window (or 0 on bad window), then move at most
    // max_step toward it, saturated to the 16-bit signed range.
    function automatic void model(input int din, input int lo,
                                  input int hi, input int ms);
        int c;
        int d;
        int nv;
        bit hit;
        bit sh;
        if (lo > hi) begin
            c   = 0;
            hit = 1'b1;
        end else begin
            c   = (din < lo) ? lo : ((din > hi) ? hi : din);
            hit = (c != din);
        end
        d  = c - m_prev;
        sh = (ms != 0) && ((d > ms) || (-d > ms));
        nv = c;
        if (sh) nv = (d > 0) ? m_prev + ms : m_prev - ms;
        if (nv > 32767) nv = 32767;
        if (nv < -32768) nv = -32768;
        exp_q.push_back('{16'(nv), hit | sh});
        m_prev = nv;
    endfunction

    always @(negedge clk) begin
        if (mon_en && dac.out_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL rnd_extra: got %h expected none",
                         dac.out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rnd_data", dac.out_data, mon_e.d);
                chk("rnd_lim", {15'd0, limiting}, {15'd0, mon_e.l});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vectors = 0;
        errors = 0;
        mon_en = 1'b0;
        reset = 1'b0;
        enable = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        upper_limit = 16'sh7FFF;
        lower_limit = 16'sh8000;
        max_step = '0;
        dac.out_ready = 1'b1;

        tbl[0] = '{16'h6000, 16'hC000, 16'h4000, 16'h4000, 1'b1, 1'b0};
        tbl[1] = '{16'h1000, 16'hC000, 16'h4000, 16'h1000, 1'b0, 1'b0};
        tbl[2] = '{16'hA000, 16'hC000, 16'h4000, 16'hC000, 1'b1, 1'b0};
        tbl[3] = '{16'h4000, 16'hC000, 16'h4000, 16'h4000, 1'b0, 1'b0};
        tbl[4] = '{16'hC000, 16'hC000, 16'h4000, 16'hC000, 1'b0, 1'b0};
        tbl[5] = '{16'h0800, 16'h1000, 16'h0F00, 16'h0000, 1'b1, 1'b1};
        tbl[6] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 1'b0, 1'b0};
        tbl[8] = '{16'h3FFF, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[9] = '{16'h4001, 16'hC000, 16'h4000, 16'h4000, 1'b1, 1'b0};

        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_data", dac.out_data, 16'h0000);
        chk("rst_valid", {15'd0, dac.out_valid}, 16'd0);
        chk("rst_lim", {15'd0, limiting}, 16'd0);
        chk("rst_cfg", {15'd0, config_error}, 16'd0);
        chk("rst_ovr", overrun_count, 16'd0);

        // slew ramp 0 -> 0x500 in 0x100 steps
        enable = 1'b1;
        max_step = 16'h0100;
        in_data = 16'sh0500;
        in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) in_valid = 1'b0;
            if (k >= 2) begin
                chk("slew_valid", {15'd0, dac.out_valid}, 16'd1);
                chk("slew_data", dac.out_data, 16'(16'h0100 * (k - 1)));
                chk("slew_lim", {15'd0, limiting},
                    {15'd0, (k - 1) < 5});
            end
        end
        tick();
        chk("slew_drop", {15'd0, dac.out_valid}, 16'd0);

        // clamp / config-error table, slew disabled
        max_step = '0;
        for (int i = 0; i < 10; i++) begin
            lower_limit = tbl[i].lo;
            upper_limit = tbl[i].hi;
            tick();
            tick();
            chk("tbl_cfg", {15'd0, config_error}, {15'd0, tbl[i].exp_cfg});
            drive_sample(tbl[i].din);
            chk("tbl_valid", {15'd0, dac.out_valid}, 16'd1);
            chk("tbl_data", dac.out_data, tbl[i].exp_out);
            chk("tbl_lim", {15'd0, limiting}, {15'd0, tbl[i].exp_lim});
            tick();
        end

        // ramp-down from 0x300 at 0x100 per sample
        lower_limit = 16'sh8000;
        upper_limit = 16'sh7FFF;
        tick();
        tick();
        drive_sample(16'h0300);
        chk("ramp_start", dac.out_data, 16'h0300);
        max_step = 16'h0100;
        enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (dac.out_valid) begin
                ramp_d.push_back(dac.out_data);
                ramp_l.push_back(limiting);
            end
        end
        chk("ramp_count", 16'(ramp_d.size()), 16'd3);
        if (ramp_d.size() == 3) begin
            chk("ramp_d0", ramp_d[0], 16'h0200);
            chk("ramp_d1", ramp_d[1], 16'h0100);
            chk("ramp_d2", ramp_d[2], 16'h0000);
            chk("ramp_l0", {15'd0, ramp_l[0]}, 16'd1);
            chk("ramp_l2", {15'd0, ramp_l[2]}, 16'd0);
        end
        chk("ramp_idle", {15'd0, dac.out_valid}, 16'd0);

        // back-pressure with overwrite
        max_step = '0;
        enable = 1'b1;
        dac.out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'sh0010;
        tick();
        in_data = 16'sh0020;
        tick();
        in_data = 16'sh0030;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("bp_valid", {15'd0, dac.out_valid}, 16'd1);
        chk("bp_data", dac.out_data, 16'h0030);
        chk("bp_ovr", overrun_count, EXP_OVR);
        dac.out_ready = 1'b1;
        tick();
        chk("bp_drop", {15'd0, dac.out_valid}, 16'd0);
        tick();
        chk("bp_stay", {15'd0, dac.out_valid}, 16'd0);

        // reset while a sample is pending
        dac.out_ready = 1'b0;
        drive_sample(16'h0040);
        chk("mr_pending", {15'd0, dac.out_valid}, 16'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mr_valid", {15'd0, dac.out_valid}, 16'd0);
        chk("mr_data", dac.out_data, 16'h0000);
        chk("mr_ovr", overrun_count, 16'd0);
        chk("mr_lim", {15'd0, limiting}, 16'd0);
        dac.out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("mr_quiet", {15'd0, dac.out_valid}, 16'd0);
        drive_sample(16'h0055);
        chk("mr_rerun", dac.out_data, 16'h0055);
        chk("mr_rerun_v", {15'd0, dac.out_valid}, 16'd1);
        tick();
        tick();

        // randomized traffic against the model
        m_prev = 32'sh55;
        mon_en = 1'b1;
        for (int b = 0; b < 20; b++) begin
            logic signed [15:0] a;
            logic signed [15:0] c;
            int r;
            a = 16'($urandom);
            c = 16'($urandom);
            lower_limit = (a < c) ? a : c;
            upper_limit = (a < c) ? c : a;
            if ($urandom_range(0, 4) == 0) begin
                lower_limit = (a < c) ? c : a;
                upper_limit = (a < c) ? a : c;
            end
            r = $urandom_range(0, 3);
            case (r)
                0: max_step = '0;
                1: max_step = 16'($urandom_range(1, 16'h00FF));
                2: max_step = 16'($urandom_range(1, 16'h2000));
                default: max_step = 16'($urandom);
            endcase
            tick();
            tick();
            tick();
            chk("rnd_cfg", {15'd0, config_error},
                {15'd0, lower_limit > upper_limit});
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 9) < 7) begin
                    in_data = 16'($urandom);
                    in_valid = 1'b1;
                    model(int'(in_data), int'(lower_limit),
                          int'(upper_limit), int'(max_step));
                end else begin
                    in_valid = 1'b0;
                end
                tick();
            end
            in_valid = 1'b0;
            tick();
            tick();
            tick();
            tick();
        end
        mon_en = 1'b0;
        chk("rnd_drained", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
